// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage: decodes alu_op/funct into an ALU function code behind a
// valid/ready output register, stalling for multiply/divide functs.
module alu_ctrl_pipe #(
  parameter int unsigned OP_W      = 4,
  parameter int unsigned FUNC_W    = 6,
  parameter int unsigned RES_W     = 6,
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [FUNC_W-1:0] func_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  result,
  output logic              illegal,
  output logic              multi_cycle,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MC_CYCLES + 1);

  localparam logic [1:0] StEmpty  = 2'd0;
  localparam logic [1:0] StFull   = 2'd1;
  localparam logic [1:0] StMcWait = 2'd2;

  localparam logic [5:0] CodeClo  = 6'b111000;
  localparam logic [5:0] CodeClz  = 6'b000111;
  localparam logic [5:0] CodeAdd  = 6'b100000;
  localparam logic [5:0] CodeAddu = 6'b100001;
  localparam logic [5:0] CodeSub  = 6'b100010;
  localparam logic [5:0] CodeBgtz = 6'b110010;
  localparam logic [5:0] CodeB    = 6'b110100;
  localparam logic [5:0] CodeBlez = 6'b110110;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic             mc_q, mc_d;

  logic [5:0]       fn6;
  logic [RES_W-1:0] dec_result;
  logic             dec_illegal;
  logic             dec_mc;
  logic             accept;

  assign fn6 = func_in[5:0];

  // Function-code decode; undefined encodings pass funct through and raise illegal.
  always_comb begin
    dec_result  = RES_W'(func_in);
    dec_illegal = 1'b0;
    case (alu_op)
      OP_W'(0): dec_result = RES_W'(func_in);
      OP_W'(1): begin
        if (fn6 == 6'b100001) begin
          dec_result = RES_W'(CodeClo);
        end else if (fn6 == 6'b100000) begin
          dec_result = RES_W'(CodeClz);
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_W'(2), OP_W'(5), OP_W'(7): dec_result = RES_W'(CodeAdd);
      OP_W'(3): dec_result = RES_W'(CodeSub);
      OP_W'(4): dec_result = RES_W'(CodeAddu);
      OP_W'(6): dec_result = RES_W'(CodeBgtz);
      OP_W'(8): dec_result = RES_W'(CodeB);
      OP_W'(9): dec_result = RES_W'(CodeBlez);
      default:  dec_illegal = 1'b1;
    endcase
  end

  // MULT/MULTU/DIV/DIVU share the 0110xx funct prefix.
  assign dec_mc = (alu_op == '0) && (fn6[5:2] == 4'b0110);

  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      case (state_q)
        StEmpty: in_ready = 1'b1;
        StFull:  in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    illegal_d = illegal_q;
    mc_d     = mc_q;
    if (flush) begin
      state_d = StEmpty;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StEmpty, StFull: begin
          if (state_q == StFull && out_ready && !accept) begin
            state_d = StEmpty;
          end
          if (accept) begin
            result_d  = dec_result;
            illegal_d = dec_illegal;
            mc_d      = dec_mc;
            if (dec_mc && (MC_CYCLES > 1)) begin
              state_d = StMcWait;
              cnt_d   = CNT_W'(MC_CYCLES - 1);
            end else begin
              state_d = StFull;
              cnt_d   = '0;
            end
          end
        end
        StMcWait: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = StFull;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = StEmpty;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
      mc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      mc_q      <= mc_d;
    end
  end

  assign out_valid   = (state_q == StFull);
  assign busy        = (state_q == StMcWait);
  assign result      = result_q;
  assign illegal     = illegal_q;
  assign multi_cycle = mc_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe with MC_CYCLES=4: decode sweep, streaming, multi-cycle
// stall, backpressure, flush and asynchronous reset.
module tb_alu_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] alu_op;
  logic [5:0] func_in;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] result;
  logic       illegal;
  logic       multi_cycle;
  logic       busy;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  alu_ctrl_pipe #(
    .OP_W(4), .FUNC_W(6), .RES_W(6), .MC_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .func_in    (func_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .illegal    (illegal),
    .multi_cycle(multi_cycle),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [5:0] fn);
    alu_op   = op;
    func_in  = fn;
    in_valid = 1'b1;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] res, input logic ill,
                            input logic mc);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".result"}, result, res);
    check({tag, ".illegal"}, illegal, ill);
    check({tag, ".mc"}, multi_cycle, mc);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; func_in = '0;
    repeat (2) step();
    check("rst.out_valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.illegal", illegal, 0);
    check("rst.mc", multi_cycle, 0);
    check("rst.result", result, 0);
    check("rst.in_ready", in_ready, 1);
    rst_n = 1'b1;

    // R-type then a streamed decode sweep, one op per cycle
    drive(4'd0, 6'b100100); step(); expect_out("rtype", 6'b100100, 0, 0);
    drive(4'd1, 6'b100001); #1; check("stream.in_ready", in_ready, 1);
    step(); expect_out("clo", 6'b111000, 0, 0);
    drive(4'd1, 6'b100000); step(); expect_out("clz", 6'b000111, 0, 0);
    drive(4'd1, 6'b000000); step(); expect_out("op1_bad", 6'b000000, 1, 0);
    drive(4'd2, 6'b010101); step(); expect_out("lw", 6'b100000, 0, 0);
    drive(4'd3, 6'b000000); step(); expect_out("beq", 6'b100010, 0, 0);
    drive(4'd4, 6'b000000); step(); expect_out("addiu", 6'b100001, 0, 0);
    drive(4'd5, 6'b000000); step(); expect_out("lbu", 6'b100000, 0, 0);
    drive(4'd6, 6'b000000); step(); expect_out("bgtz", 6'b110010, 0, 0);
    drive(4'd7, 6'b000000); step(); expect_out("sb", 6'b100000, 0, 0);
    drive(4'd8, 6'b000000); step(); expect_out("b", 6'b110100, 0, 0);
    drive(4'd9, 6'b000000); step(); expect_out("blez", 6'b110110, 0, 0);
    drive(4'd12, 6'b010101); step(); expect_out("op12", 6'b010101, 1, 0);
    drive(4'd10, 6'b111111); step(); expect_out("op10", 6'b111111, 1, 0);
    in_valid = 1'b0; step();
    check("drain.out_valid", out_valid, 0);
    check("drain.in_ready", in_ready, 1);

    // DIV: three busy cycles, second op offered meanwhile must be ignored
    drive(4'd0, 6'b011010); step();
    drive(4'd0, 6'b100100); #1;
    for (int i = 0; i < 3; i++) begin
      check("mc.busy", busy, 1);
      check("mc.in_ready", in_ready, 0);
      check("mc.out_valid", out_valid, 0);
      step();
    end
    check("mc.busy_done", busy, 0);
    expect_out("div", 6'b011010, 0, 1);
    in_valid = 1'b0; step();
    check("mc.drop", out_valid, 0);

    // Backpressure: hold for 5 cycles, then swap without a bubble
    drive(4'd4, 6'b000000); step(); expect_out("bp.first", 6'b100001, 0, 0);
    out_ready = 1'b0; drive(4'd3, 6'b000000);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp.in_ready", in_ready, 0);
      expect_out("bp.hold", 6'b100001, 0, 0);
      step();
    end
    out_ready = 1'b1; #1;
    check("bp.release_ready", in_ready, 1);
    step(); expect_out("bp.swap", 6'b100010, 0, 0);
    in_valid = 1'b0; step();

    // Flush during MC_WAIT with a concurrent offer
    drive(4'd0, 6'b011000); step();
    check("fl.busy", busy, 1);
    flush = 1'b1; drive(4'd0, 6'b100100); #1;
    check("fl.in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0; #1;
    check("fl.busy_clr", busy, 0);
    check("fl.out_valid", out_valid, 0);
    check("fl.in_ready_after", in_ready, 1);
    step();
    check("fl.no_accept", out_valid, 0);

    // Asynchronous reset in MC_WAIT
    drive(4'd0, 6'b011011); step();
    in_valid = 1'b0;
    check("ar.busy", busy, 1);
    #1 rst_n = 1'b0; #1;
    check("ar.busy_clr", busy, 0);
    check("ar.valid_clr", out_valid, 0);
    check("ar.result_clr", result, 0);
    check("ar.mc_clr", multi_cycle, 0);
    step(); rst_n = 1'b1;
    repeat (4) step();
    check("ar.no_output", out_valid, 0);
    check("ar.no_busy", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
